// File: rtl/dbus_timer_pkg.sv
// Shared types, register offsets and helpers for the dbus machine timer.
// Offsets are word indices (byte address bits [4:2]) within the timer window.
package dbus_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    localparam logic [2:0] TIMER_MTIME_LO = 3'd0;
    localparam logic [2:0] TIMER_MTIME_HI = 3'd1;
    localparam logic [2:0] TIMER_CMP_LO   = 3'd2;
    localparam logic [2:0] TIMER_CMP_HI   = 3'd3;
    localparam logic [2:0] TIMER_CTRL     = 3'd4;
    localparam logic [2:0] TIMER_DIV      = 3'd5;

    localparam int unsigned TIMER_WIN_SIZE = 32;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] cur,
        input logic [31:0] wdat,
        input logic [3:0]  mask
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = mask[i] ? wdat[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dbus_timer_prescaler.sv
// Prescale divider for the machine timer.
// Emits a tick every (div+1) enabled cycles; clr restarts the count.
module dbus_timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    input  logic                  clr,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    // Tick when the count reaches the divider; count wraps, holds or clears.
    always_comb begin
        tick  = en && (cnt_q == div);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dbus_timer.sv
// Machine timer peripheral on the core data bus.
// 64-bit mtime/mtimecmp, enable/irq-enable control and a prescaler.
module dbus_timer
    import dbus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_dbus_req,
    input  logic        I_dbus_we,
    input  logic [31:0] I_dbus_addr,
    input  logic [31:0] I_dbus_data,
    input  logic [3:0]  I_dbus_mask,
    output logic [31:0] O_dbus_data,
    output logic        O_dbus_ready,
    output logic        O_timer_int
);

    state_e                state_q, state_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           cmp_q, cmp_d;
    logic                  en_q, en_d;
    logic                  ie_q, ie_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  int_q, int_d;

    logic                  sel;
    logic                  accept;
    logic [2:0]            off;
    logic                  tick;
    logic                  clr;
    logic [31:0]           div_m;
    logic [31:0]           ctrl_m;
    logic                  wr_unused;

    assign sel    = (I_dbus_addr[31:5] == BASE_ADDR[31:5]);
    assign accept = (state_q == ST_IDLE) && I_dbus_req && sel;
    assign off    = I_dbus_addr[4:2];

    assign div_m  = byte_merge({{(32-PRESCALE_W){1'b0}}, div_q},
                               I_dbus_data, I_dbus_mask);
    assign ctrl_m = byte_merge({30'b0, ie_q, en_q},
                               I_dbus_data, I_dbus_mask);

    assign wr_unused = ^{I_dbus_addr[1:0], ctrl_m[31:2],
                         div_m[31:PRESCALE_W]};

    dbus_timer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_presc (
        .clk (clk),
        .rst (rst),
        .en  (en_q),
        .div (div_q),
        .clr (clr),
        .tick(tick)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one response cycle after every accepted access.
    always_comb begin
        state_d = ST_IDLE;
        if (state_q == ST_IDLE && accept) begin
            state_d = ST_RESP;
        end
    end

    // FSM outputs: ready pulse with data valid only in RESP.
    always_comb begin
        O_dbus_ready = (state_q == ST_RESP);
        O_dbus_data  = rdata_q;
        O_timer_int  = int_q;
    end

    // Register file update, counter advance and read capture.
    always_comb begin
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        cmp_d   = cmp_q;
        en_d    = en_q;
        ie_d    = ie_q;
        div_d   = div_q;
        clr     = 1'b0;
        rdata_d = '0;
        if (accept && I_dbus_we) begin
            case (off)
                TIMER_MTIME_LO: mtime_d = {mtime_q[63:32],
                    byte_merge(mtime_q[31:0], I_dbus_data, I_dbus_mask)};
                TIMER_MTIME_HI: mtime_d = {
                    byte_merge(mtime_q[63:32], I_dbus_data, I_dbus_mask),
                    mtime_q[31:0]};
                TIMER_CMP_LO: cmp_d = {cmp_q[63:32],
                    byte_merge(cmp_q[31:0], I_dbus_data, I_dbus_mask)};
                TIMER_CMP_HI: cmp_d = {
                    byte_merge(cmp_q[63:32], I_dbus_data, I_dbus_mask),
                    cmp_q[31:0]};
                TIMER_CTRL: begin
                    en_d = ctrl_m[0];
                    ie_d = ctrl_m[1];
                end
                TIMER_DIV: begin
                    div_d = div_m[PRESCALE_W-1:0];
                    clr   = 1'b1;
                end
                default: ;
            endcase
        end else if (accept) begin
            case (off)
                TIMER_MTIME_LO: rdata_d = mtime_q[31:0];
                TIMER_MTIME_HI: rdata_d = mtime_q[63:32];
                TIMER_CMP_LO:   rdata_d = cmp_q[31:0];
                TIMER_CMP_HI:   rdata_d = cmp_q[63:32];
                TIMER_CTRL:     rdata_d = {30'b0, ie_q, en_q};
                TIMER_DIV:      rdata_d = {{(32-PRESCALE_W){1'b0}}, div_q};
                default:        rdata_d = '0;
            endcase
        end
        int_d = ie_q && (mtime_q >= cmp_q);
    end

    // Timer state, response data and interrupt flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q <= '0;
            cmp_q   <= '1;
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            div_q   <= '0;
            rdata_q <= '0;
            int_q   <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            div_q   <= div_d;
            rdata_q <= rdata_d;
            int_q   <= int_d;
        end
    end

endmodule

// File: tb/tb_dbus_timer.sv
// Scoreboard bench for dbus_timer: directed accesses push expected read data,
// a negedge monitor pops and compares on every ready pulse.
module tb_dbus_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;

    localparam logic [4:0] A_MLO  = 5'h00;
    localparam logic [4:0] A_MHI  = 5'h04;
    localparam logic [4:0] A_CLO  = 5'h08;
    localparam logic [4:0] A_CHI  = 5'h0C;
    localparam logic [4:0] A_CTRL = 5'h10;
    localparam logic [4:0] A_DIV  = 5'h14;
    localparam logic [4:0] A_R18  = 5'h18;
    localparam logic [4:0] A_R1C  = 5'h1C;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        ready;
    logic        tint;

    typedef struct {
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks;
    int   n_fail;

    dbus_timer dut (
        .clk         (clk),
        .rst         (rst),
        .I_dbus_req  (req),
        .I_dbus_we   (we),
        .I_dbus_addr (addr),
        .I_dbus_data (wdata),
        .I_dbus_mask (mask),
        .O_dbus_data (rdata),
        .O_dbus_ready(ready),
        .O_timer_int (tint)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access: accept on the first posedge, ready the cycle after.
    task automatic access(input logic w, input logic [4:0] o,
                          input logic [31:0] d, input logic [3:0] m,
                          input logic [31:0] exp, input string name);
        exp_t x;
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = BASE + {27'b0, o};
        wdata = d;
        mask  = m;
        x.data = exp;
        x.name = name;
        sb_q.push_back(x);
        check({name, "_ready_before"}, ready, 0);
        @(posedge clk);
        #1;
        req = 1'b0;
        check({name, "_ready_lat"}, ready, 1);
        @(posedge clk);
        #1;
        check({name, "_ready_drop"}, ready, 0);
    endtask

    task automatic wr(input logic [4:0] o, input logic [31:0] d,
                      input logic [3:0] m);
        access(1'b1, o, d, m, 32'h0, "wr");
    endtask

    task automatic rd(input logic [4:0] o, input logic [31:0] exp,
                      input string name);
        access(1'b0, o, 32'h0, 4'hF, exp, name);
    endtask

    // Monitor: compare every response against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got data %h expected no response",
                             rdata);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, rdata, e.data);
                end
            end else begin
                check("idle_data_zero", rdata, 0);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        mask  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_int", tint, 0);
        check("rst_ready", ready, 0);
        check("rst_data", rdata, 0);
        @(negedge clk);
        rst = 1'b1;

        // Reset while the response is pending.
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        addr = BASE + 32'h10;
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("midresp_ready", ready, 0);
        @(negedge clk);
        check("midresp_ready2", ready, 0);
        rst = 1'b1;

        rd(A_CHI, 32'hFFFF_FFFF, "cmp_hi_rst");
        rd(A_CLO, 32'hFFFF_FFFF, "cmp_lo_rst");
        rd(A_MLO, 32'h0, "mtime_lo_rst");
        check("int_after_rst", tint, 0);

        rd(A_CTRL, 32'h0, "ctrl_rst");

        // Outside the window: no response at all.
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        addr = BASE + 32'h40;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("oow_ready", ready, 0);
        end
        req = 1'b0;

        // Byte-masked write.
        wr(A_CLO, 32'h1122_3344, 4'hF);
        wr(A_CLO, 32'hAABB_CCDD, 4'b0101);
        rd(A_CLO, 32'h11BB_33DD, "masked_cmp_lo");

        // Reserved offsets and ctrl upper bits.
        wr(A_R18, 32'hDEAD_BEEF, 4'hF);
        rd(A_R18, 32'h0, "resv_18");
        rd(A_R1C, 32'h0, "resv_1c");
        wr(A_CTRL, 32'hFFFF_FFFC, 4'hF);
        rd(A_CTRL, 32'h0, "ctrl_upper");

        // Prescaler div=3: one tick every 4 cycles.
        wr(A_DIV, 32'h3, 4'hF);
        rd(A_DIV, 32'h3, "div_rb");
        wr(A_CTRL, 32'h1, 4'hF);
        repeat (19) @(posedge clk);
        rd(A_MLO, 32'd5, "presc_20cyc");
        wr(A_DIV, 32'h3, 4'hF);
        repeat (2) @(posedge clk);
        rd(A_MLO, 32'd5, "presc_clr");

        // Low word carry into high word.
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_MHI, 32'h0, 4'hF);
        wr(A_MLO, 32'hFFFF_FFFF, 4'hF);
        wr(A_DIV, 32'h0, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        rd(A_MHI, 32'h1, "carry_hi");
        rd(A_MLO, 32'h2, "carry_lo");

        // 64-bit wrap.
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_MHI, 32'hFFFF_FFFF, 4'hF);
        wr(A_MLO, 32'hFFFF_FFFF, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        rd(A_MHI, 32'h0, "wrap_hi");
        rd(A_MLO, 32'h2, "wrap_lo");

        // Interrupt rise one cycle after mtime reaches mtimecmp.
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_MLO, 32'h0, 4'hF);
        wr(A_MHI, 32'h0, 4'hF);
        wr(A_CHI, 32'h0, 4'hF);
        wr(A_CLO, 32'd10, 4'hF);
        check("int_ie_off", tint, 0);
        wr(A_CTRL, 32'h3, 4'hF);
        repeat (9) @(posedge clk);
        #1;
        check("int_at_10", tint, 0);
        @(posedge clk);
        #1;
        check("int_rise", tint, 1);
        wr(A_CLO, 32'hFFFF_FFFF, 4'hF);
        check("int_fall_cmp", tint, 0);

        // Write on a tick edge suppresses the increment.
        wr(A_MLO, 32'h0000_0100, 4'hF);
        rd(A_MLO, 32'h0000_0101, "wr_on_tick");

        // Clearing ie drops the interrupt.
        wr(A_CLO, 32'h0, 4'hF);
        check("int_cmp0", tint, 1);
        wr(A_CTRL, 32'h1, 4'hF);
        check("int_ie_clr", tint, 0);

        repeat (3) @(posedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
